// File: rtl/maple_stream_decoder.sv
// maple_stream_decoder: Maple bus bit sampler, byte packer and AXI-Stream output FIFO.
// Define MAPLE_CHECKSUM_EN to build the end-of-frame XOR checksum check.
module maple_stream_decoder #(
   parameter int BYTES = 1,
   parameter int DEPTH = 8
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 enable,
   input  logic                 sdcka_data,
   input  logic                 sdcka_negedge,
   input  logic                 sdckb_data,
   input  logic                 sdckb_negedge,
   output logic [8*BYTES-1:0]   m_axis_tdata,
   output logic [BYTES-1:0]     m_axis_tkeep,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 overflow,
   output logic                 frame_error,
   output logic                 checksum_error
);
   localparam int W  = 8 * BYTES;
   localparam int CW = $clog2(BYTES + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = W + BYTES + 1;
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   typedef enum logic [1:0] {IDLE, PHASE1, PHASE2, FLUSH} state_t;

   state_t       state_q;
   logic [2:0]   bit_q;
   logic [6:0]   sh_q;
   logic [7:0]   hold_q;
   logic         hold_v_q;
   logic         frame_error_q;
   logic         samp, sbit, done, in_v, in_last, closing;

   logic [W-1:0]     pk_data_q, pk_data_d;
   logic [CW-1:0]    pk_cnt_q, pk_cnt_d;
   logic             pk_last_q, pk_last_d;
   logic [BYTES-1:0] pk_keep;
   logic [AW:0]      wp_q, rp_q;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    head;
   logic             push, pop, full, wr, overflow_q;

   always_comb begin
      samp    = enable && state_q != FLUSH && (state_q == PHASE2 ? sdckb_negedge : sdcka_negedge);
      sbit    = state_q == PHASE2 ? sdcka_data : sdckb_data;
      done    = samp && bit_q == 3'd7;
      in_last = state_q == FLUSH;
      in_v    = hold_v_q && (done || in_last);
      closing = !enable && (state_q == PHASE1 || state_q == PHASE2);
   end

`ifdef MAPLE_CHECKSUM_EN
   logic [7:0] xr_q;
   logic       moved_q, cks_q;
   assign checksum_error = cks_q;
`else
   assign checksum_error = 1'b0;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         bit_q         <= '0;
         sh_q          <= '0;
         hold_q        <= '0;
         hold_v_q      <= 1'b0;
         frame_error_q <= 1'b0;
`ifdef MAPLE_CHECKSUM_EN
         xr_q          <= '0;
         moved_q       <= 1'b0;
         cks_q         <= 1'b0;
`endif
      end else begin
         frame_error_q <= closing && bit_q != 3'd0;
         if (samp) begin
            sh_q  <= {sh_q[5:0], sbit};
            bit_q <= bit_q + 3'd1;
         end
         if (done) begin
            hold_q   <= {sh_q, sbit};
            hold_v_q <= 1'b1;
         end
         unique case (state_q)
            IDLE:   if (enable) state_q <= samp ? PHASE2 : PHASE1;
            PHASE1: state_q <= !enable ? FLUSH : samp ? PHASE2 : PHASE1;
            PHASE2: state_q <= !enable ? FLUSH : samp ? PHASE1 : PHASE2;
            FLUSH: begin
               state_q  <= IDLE;
               bit_q    <= '0;
               sh_q     <= '0;
               hold_v_q <= 1'b0;
            end
         endcase
`ifdef MAPLE_CHECKSUM_EN
         // Held byte at close is the frame's last byte; every earlier one is already folded in.
         cks_q <= closing && moved_q && hold_v_q && xr_q != hold_q;
         if (in_v && !in_last) begin
            xr_q    <= xr_q ^ hold_q;
            moved_q <= 1'b1;
         end
         if (in_last) begin
            xr_q    <= '0;
            moved_q <= 1'b0;
         end
`endif
      end
   end

   always_comb begin
      push      = pk_last_q || pk_cnt_q == CW'(BYTES);
      pop       = m_axis_tvalid && m_axis_tready;
      full      = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
      wr        = push && (!full || pop);
      pk_data_d = push ? '0 : pk_data_q;
      pk_cnt_d  = push ? '0 : pk_cnt_q;
      pk_last_d = 1'b0;
      if (in_v) begin
         for (int i = 0; i < BYTES; i++)
            if (CW'(i) == pk_cnt_d) pk_data_d[8*i +: 8] = hold_q;
         pk_cnt_d  = pk_cnt_d + CW'(1);
         pk_last_d = in_last;
      end
      for (int i = 0; i < BYTES; i++) pk_keep[i] = CW'(i) < pk_cnt_q;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pk_data_q  <= '0;
         pk_cnt_q   <= '0;
         pk_last_q  <= 1'b0;
         wp_q       <= '0;
         rp_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         pk_data_q <= pk_data_d;
         pk_cnt_q  <= pk_cnt_d;
         pk_last_q <= pk_last_d;
         if (wr) wp_q <= wp_q + PTR_ONE;
         if (pop) rp_q <= rp_q + PTR_ONE;
         if (state_q == IDLE && enable) overflow_q <= 1'b0;
         if (push && full && !pop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge aclk) if (wr) mem_q[wp_q[AW-1:0]] <= {pk_data_q, pk_keep, pk_last_q};

   assign head          = mem_q[rp_q[AW-1:0]];
   assign m_axis_tvalid = wp_q != rp_q;
   assign m_axis_tdata  = m_axis_tvalid ? head[EW-1 -: W] : '0;
   assign m_axis_tkeep  = m_axis_tvalid ? head[BYTES:1] : '0;
   assign m_axis_tlast  = m_axis_tvalid && head[0];
   assign overflow      = overflow_q;
   assign frame_error   = frame_error_q;
endmodule

// File: doc/maple_stream_decoder.md
Name: maple_stream_decoder

Overview:
Parametrised successor to the single-byte Maple bus data decoder. Samples the two-wire Maple bus from pre-detected SDCKA/SDCKB edge strobes. Assembles bytes MSB-first and packs them into BYTES-wide AXI-Stream words. A DEPTH-entry FIFO provides backpressure. tlast is asserted on the word carrying the real final byte; no extra marker beat is emitted. Sits between the bus edge detectors and the receive DMA/stream fabric.

Parameters:
BYTES, 1, byte lanes per output word (1, 2 or 4)
DEPTH, 8, output FIFO entries (power of 2, >= 2)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous assert, active-low
enable  in  1  frame active, driven by the start/end pattern detector
sdcka_data  in  1  synchronised SDCKA level
sdcka_negedge  in  1  one-cycle strobe on an SDCKA falling edge
sdckb_data  in  1  synchronised SDCKB level
sdckb_negedge  in  1  one-cycle strobe on an SDCKB falling edge
m_axis_tdata  out  8*BYTES  packed bytes; first byte in [7:0]
m_axis_tkeep  out  BYTES  valid-lane mask, contiguous from lane 0
m_axis_tlast  out  1  final word of the frame
m_axis_tvalid  out  1  FIFO not empty
m_axis_tready  in  1  downstream accept
overflow  out  1  sticky: a word was dropped because the FIFO was full
frame_error  out  1  one-cycle pulse: frame ended with a partial byte (1-7 bits)
checksum_error  out  1  one-cycle pulse at frame end (see Optional Feature)

Behaviour:
- Reset: all outputs 0. FSM in IDLE. FIFO empty. Counters, packer and hold register cleared. Reset mid-frame discards the partial frame; no words are emitted for it.
- FSM states: IDLE, PHASE1, PHASE2, FLUSH.
  - IDLE: if enable=1, go to PHASE1 and clear overflow. A sdcka_negedge in that same cycle is sampled immediately, as in PHASE1.
  - PHASE1: on sdcka_negedge, shift in sdckb_data and go to PHASE2.
  - PHASE2: on sdckb_negedge, shift in sdcka_data and go to PHASE1.
  - In PHASE1 or PHASE2: enable=0 goes to FLUSH. enable low takes priority over any edge strobe in the same cycle; that edge is ignored.
  - FLUSH: lasts one cycle, then IDLE. enable is not sampled in FLUSH.
- Bit counter, 3 bits: wraps 7->0 on byte completion.
- Hold register: a completed byte goes into the hold register. When the next byte completes, the held byte is moved to the packer with last=0.
- In FLUSH:
  - A held byte moves to the packer with last=1.
  - Bit counter != 0: discard the partial bits and pulse frame_error.
  - A frame with zero complete bytes emits nothing.
- Packer:
  - Fills lanes starting at lane 0.
  - Pushes a word to the FIFO when all BYTES lanes are full, or when a last byte arrives.
  - Unfilled lanes carry 0 with tkeep=0.
  - The push happens in the cycle after the byte enters the packer.
- FIFO:
  - Each entry holds {tdata, tkeep, tlast}. The outputs are driven from the head.
  - Pop on tvalid && tready.
  - A pushed word is visible on m_axis_* the cycle after the push.
  - Push while full with no pop: the word is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed.
  - tvalid/tdata are held stable while tready=0.
- Throughput: one word per cycle sustained.

Optional Feature:
MAPLE_CHECKSUM_EN
- Defined:
  - A running XOR over every completed byte except the last one of the frame.
  - In FLUSH, compare it with the last byte. On mismatch, checksum_error pulses for one cycle, coincident with the frame_error timing.
  - The data is still delivered unchanged.
  - A frame of 0 or 1 bytes produces no checksum check.
- Undefined: checksum_error is tied to 0 and no XOR logic is built.

Test Plan:
1. BYTES=2, tready=1, frame of bytes 0x12,0x34,0x56 -> word tdata=0x3412 keep=2'b11 last=0, then word tdata=0x0056 keep=2'b01 last=1. No frame_error; exactly 2 beats.
2. BYTES=1, DEPTH=4, tready=0, 6-byte frame -> 4 entries held and overflow=1. With tready=1, exactly 4 beats drain (last entry carries the 4th byte, last=0). overflow clears at the next enable rise.
3. BYTES=1, frame of 12 bits (byte 0xA5 then 4 bits) -> single beat 0xA5 with last=1, and a frame_error pulse in the FLUSH cycle.
4. enable falls in the same cycle as sdckb_negedge completing bit 8 of byte 2 -> only byte 1 is emitted, with last=1; frame_error=1.
5. aresetn pulsed low mid-frame with 2 words already queued -> tvalid=0 immediately, FIFO empty. The next full frame 0x01 (BYTES=1) emits exactly one beat with last=1.
6. MAPLE_CHECKSUM_EN defined: frame 0x01,0x02,0x03 -> checksum_error stays 0. Frame 0x01,0x02,0x04 -> one-cycle checksum_error pulse; all 3 bytes are still delivered.
